// File: rtl/dsp_pkg.sv
// dsp_pkg: sequencer states, OPMODE words and the DSP48A1 build configuration it assumes
package dsp_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, FINISH} state_t;
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam int A0REG = 0;
   localparam int A1REG = 1;
   localparam int B0REG = 0;
   localparam int B1REG = 1;
   localparam int MREG = 1;
   localparam int PREG = 1;
   localparam int OPMODEREG = 1;
   localparam string B_INPUT = "DIRECT";
   localparam string CARRYINSEL = "OPMODE5";
endpackage

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives DSP48A1 clock enables, resets and OPMODE to accumulate a LEN-pair dot product
module dsp_mac_sequencer import dsp_pkg::*; #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [CNT_WIDTH-1:0] LEN,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 CEA,
   output logic                 CEB,
   output logic                 CEM,
   output logic                 CEP,
   output logic                 CEOPMODE,
   output logic                 CEC,
   output logic                 CED,
   output logic                 CECARRYIN,
   output logic                 RSTA,
   output logic                 RSTB,
   output logic                 RSTM,
   output logic                 RSTP,
   output logic                 RSTC,
   output logic                 RSTD,
   output logic                 RSTCARRYIN,
   output logic                 RSTOPMODE,
   output logic [7:0]           OPMODE
);
   state_t state, state_nxt;
   logic [CNT_WIDTH-1:0] len_q, cnt;
   logic [1:0] vpipe;
   logic first, acc, last;
   assign acc  = state == RUN && IN_VALID;
   assign last = cnt == len_q - CNT_WIDTH'(1);
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         len_q <= '0;
         cnt   <= '0;
         vpipe <= '0;
         first <= 1'b0;
      end else begin
         state <= state_nxt;
         vpipe <= {vpipe[0], acc};
         if (state == IDLE && START) begin
            len_q <= LEN;
            cnt   <= '0;
         end else if (acc)
            cnt <= cnt + CNT_WIDTH'(1);
         first <= state == CLEAR ? 1'b1 : vpipe[0] ? 1'b0 : first;
      end
   end
   // DRAIN exits once the last pair has left the M stage; its CEP lands in this cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = START ? CLEAR : IDLE;
         CLEAR:   state_nxt = len_q != '0 ? RUN : FINISH;
         RUN:     state_nxt = acc && last ? DRAIN : RUN;
         DRAIN:   state_nxt = vpipe[0] ? DRAIN : FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   assign IN_READY   = !RST && state == RUN;
   assign BUSY       = !RST && state != IDLE;
   assign DONE       = !RST && state == FINISH;
   assign CEA        = !RST && acc;
   assign CEB        = !RST && acc;
   assign CEM        = !RST && vpipe[0];
   assign CEOPMODE   = !RST && vpipe[0];
   assign CEP        = !RST && vpipe[1];
   assign OPMODE     = RST || !vpipe[0] ? 8'h00 : first ? OPM_FIRST : OPM_ACC;
   assign CEC        = 1'b0;
   assign CED        = 1'b0;
   assign CECARRYIN  = 1'b0;
   assign RSTA       = RST;
   assign RSTB       = RST;
   assign RSTC       = RST;
   assign RSTD       = RST;
   assign RSTCARRYIN = RST;
   assign RSTOPMODE  = RST;
   assign RSTM       = RST || state == CLEAR;
   assign RSTP       = RST || state == CLEAR;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: sequencer plus a behavioural DSP48A1 stand-in, checked against a cycle-schedule model
module tb_dsp_mac_sequencer;
   import dsp_pkg::*;
   localparam int CW = 4;
   logic CLK = 1'b0, RST = 1'b1, START = 1'b0, IN_VALID = 1'b0;
   logic [CW-1:0] LEN = '0;
   logic [17:0] A = '0, B = '0;
   logic IN_READY, BUSY, DONE, CEA, CEB, CEM, CEP, CEOPMODE, CEC, CED, CECARRYIN;
   logic RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE;
   logic [7:0] OPMODE;
   logic [17:0] a1 = '0, b1 = '0;
   logic [35:0] m_r = '0;
   logic [7:0] opm_r = '0;
   logic [47:0] p_r = '0;
   int n_chk = 0, n_fail = 0, cyc = 0, s = 0;
   bit m_act = 0, m_first = 0;
   int m_start = 0, m_len = 0, m_acc = 0, m_done = -1;
   longint m_sum = 0;
   bit acc_at[int];
   logic e_rdy, e_cem, e_cep, e_busy, e_done, e_clr;

   always #5 CLK = ~CLK;

   dsp_mac_sequencer #(.CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .BUSY(BUSY), .DONE(DONE),
      .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEOPMODE(CEOPMODE),
      .CEC(CEC), .CED(CED), .CECARRYIN(CECARRYIN),
      .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC),
      .RSTD(RSTD), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE), .OPMODE(OPMODE)
   );

   // DSP48A1 with A1/B1, M, P and OPMODE registers; X=M when OPMODE[1:0]=01, Z=P when OPMODE[3]
   always @(posedge CLK) begin
      a1    <= RSTA ? '0 : CEA ? A : a1;
      b1    <= RSTB ? '0 : CEB ? B : b1;
      m_r   <= RSTM ? '0 : CEM ? a1 * b1 : m_r;
      opm_r <= RSTOPMODE ? '0 : CEOPMODE ? OPMODE : opm_r;
      p_r   <= RSTP ? '0 : CEP ? (opm_r[3] ? p_r : 48'd0) + (opm_r[1:0] == 2'b01 ? {12'd0, m_r} : 48'd0) : p_r;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Schedule model: ready from START+2 until LEN pairs taken; M at accept+1, P at accept+2, DONE at last+3
   always @(negedge CLK) begin
      e_rdy  = !RST && m_act && cyc >= m_start + 2 && m_acc < m_len;
      e_cem  = !RST && acc_at.exists(cyc - 1);
      e_cep  = !RST && acc_at.exists(cyc - 2);
      e_busy = !RST && m_act && cyc > m_start;
      e_done = !RST && m_act && cyc == m_done;
      e_clr  = RST || (m_act && cyc == m_start + 1);
      chk("in_ready", IN_READY, e_rdy);
      chk("busy", BUSY, e_busy);
      chk("done", DONE, e_done);
      chk("cea", CEA, e_rdy && IN_VALID);
      chk("ceb", CEB, e_rdy && IN_VALID);
      chk("cem", CEM, e_cem);
      chk("ceopmode", CEOPMODE, e_cem);
      chk("cep", CEP, e_cep);
      chk("rstm", RSTM, e_clr);
      chk("rstp", RSTP, e_clr);
      chk("unused_ce", {CEC, CED, CECARRYIN}, 3'b000);
      chk("static_rst", {RSTA, RSTB, RSTC, RSTD, RSTCARRYIN}, {5{RST}});
      if (RST) begin
         chk("rst_opmode", OPMODE, 8'h00);
         chk("rst_rstopmode", RSTOPMODE, 1'b1);
      end else if (e_cem) begin
         chk("opmode", OPMODE, m_first ? OPM_FIRST : OPM_ACC);
         m_first = 0;
      end
      if (e_done) chk("p_final_model", p_r, m_sum[47:0]);
      if (RST) begin
         m_act = 0;
         acc_at.delete();
      end else begin
         if (!m_act && START) begin
            m_act = 1; m_start = cyc; m_len = int'(LEN); m_acc = 0; m_sum = 0; m_first = 1;
            m_done = LEN == '0 ? cyc + 2 : -1;
         end
         if (e_rdy && IN_VALID) begin
            acc_at[cyc] = 1;
            m_acc++;
            m_sum += longint'(A) * longint'(B);
            if (m_acc == m_len) m_done = cyc + 3;
         end
         if (e_done) m_act = 0;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_job(input int len);
      START = 1'b1;
      LEN = CW'(len);
      s = cyc;
      tick();
      START = 1'b0;
   endtask

   task automatic send(input int a, input int b);
      bit ok = 0;
      int n = 0;
      A = 18'(a); B = 18'(b); IN_VALID = 1'b1;
      while (!ok && n < 50) begin
         @(negedge CLK);
         ok = IN_READY;
         tick();
         n++;
      end
      IN_VALID = 1'b0;
      chk("pair_accepted", ok, 1'b1);
   endtask

   task automatic wait_done(input string name, input longint exp_p, input int exp_lat);
      bit seen = 0;
      int n = 0;
      while (!seen && n < 200) begin
         @(negedge CLK);
         #1;
         seen = DONE;
         n++;
      end
      chk({name, "_done_seen"}, seen, 1'b1);
      chk({name, "_p"}, p_r, exp_p[47:0]);
      if (exp_lat >= 0) chk({name, "_latency"}, cyc - s - 1, exp_lat);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk("reset_busy", BUSY, 1'b0);
      chk("reset_ready", IN_READY, 1'b0);
      chk("reset_opmode", OPMODE, 8'h00);
      chk("reset_dsp_rsts", {RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE}, 8'hFF);
      RST = 1'b0;
      tick();
      start_job(4);
      send(1, 2); send(3, 4); send(5, 6); send(7, 8);
      wait_done("len4", 100, 8);
      start_job(4);
      send(1, 2); send(3, 4);
      tick(); tick();
      send(5, 6); send(7, 8);
      wait_done("bubble", 100, 10);
      start_job(2);
      send(3, 3); send(2, 2);
      wait_done("b2b_a", 13, 6);
      start_job(1);
      send(5, 5);
      wait_done("b2b_b", 25, 5);
      start_job(0);
      wait_done("len0", 0, 2);
      start_job(5);
      send(1, 1); send(2, 2);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("post_rst_ce", {CEA, CEB, CEM, CEP, CEOPMODE}, 5'b00000);
      chk("post_rst_busy", BUSY, 1'b0);
      repeat (5) tick();
      start_job(1);
      send(9, 9);
      wait_done("after_rst", 81, 5);
      start_job(3);
      send(2, 3);
      START = 1'b1;
      LEN = CW'(7);
      send(4, 5);
      START = 1'b0;
      send(6, 7);
      wait_done("ignore_start", 68, 7);
      start_job(15);
      for (int i = 1; i <= 15; i++) send(i, 2);
      wait_done("len_max", 240, 19);
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
